iob_fifo_fwft_rd: RTL and testbench
===================================

Name: iob_fifo_fwft_rd

Overview:
- Read-side stage placed directly downstream of the asynchronous (asymmetric) FIFO read port, in the read clock domain.
- Converts the FIFO's standard-mode port (read_en in, data_out registered one cycle later, empty flag) into a first-word-fall-through valid/ready stream.
- Holds a 3-entry output buffer and tracks the in-flight read, so it sustains 1 word/cycle.
- No combinational path from m_ready to fifo_read_en.

Parameters:
DATA_W  8  word width; equals R_DATA_W of the FIFO feeding it
BUF_DEPTH  3  output buffer entries; fixed at 3, exposed only as a localparam-checked constant (must be >= 3)

Ports:
clk  input  1  clock (FIFO rclk domain)
rst  input  1  reset, asynchronous, active-high
fifo_empty  input  1  FIFO empty flag
fifo_read_en  output  1  read strobe to FIFO
fifo_data_in  input  DATA_W  FIFO data_out, valid the cycle after fifo_read_en
m_valid  output  1  stream data valid
m_ready  input  1  stream consumer ready
m_data  output  DATA_W  stream data (head of buffer)
level  output  2  buffer occupancy, 0..3

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset values: count=0, inflight=0, wr_ptr=rd_ptr=0, all buffer entries=0, m_valid=0, m_data=0, level=0, fifo_read_en=0 (combinational from reset-zeroed state).
- Issue rule (combinational on registered state plus fifo_empty only):
  - fifo_read_en = ~fifo_empty & ((count + inflight) < BUF_DEPTH).
  - m_ready must never influence fifo_read_en.
- inflight: register loaded with fifo_read_en every cycle.
- Push: when inflight=1, fifo_data_in is written to buf[wr_ptr] at the clock edge ending that cycle; wr_ptr advances mod 3.
- Pop: pop = m_valid & m_ready; rd_ptr advances mod 3.
- Outputs: m_valid = (count != 0); m_data = buf[rd_ptr]; level = count.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Occupancy bound: count + inflight <= 3 always. A push never finds the buffer full; overflow is impossible by construction.
- Assertion (sim only): push while count==3 is a fatal error.
- Latency: fifo_empty falls in cycle N → fifo_read_en=1 in N → data captured at end of N+1 → m_valid=1 in N+2.
- Throughput: with m_ready held high and the FIFO non-empty, steady state is count=1, inflight=1, one pop and one issue per cycle.
- Backpressure:
  - m_ready low → buffer fills to 3 (2 reads issued after the stall starts are absorbed) and fifo_read_en drops.
  - Reads resume the cycle after the first pop brings count+inflight < 3.
- Stream rules:
  - m_data/m_valid are held stable while m_valid & ~m_ready.
  - m_valid never deasserts without a pop.
- FIFO empty mid-stream: no issue; buffered words continue to drain; m_valid falls after the last pop.
- Wrap-around: pointers wrap 2→0; no ordering change across the wrap.
- Reset mid-operation:
  - All state clears immediately.
  - An in-flight word is discarded; its data on fifo_data_in the next cycle is ignored because inflight=0.
  - The FIFO is reset by the same rst, so the streams stay aligned.

Decomposition:
- Shared package (iob_fifo_pkg): BUF_DEPTH=3, LEVEL_W=2, and a mod-3 pointer-increment function.
- One sub-module is natural: iob_fifo_fwft_buf, a 3-entry register buffer with push/pop, pointers and count.
- Top level holds only the issue logic and the inflight register.

Test Plan:
- Reset then fifo_empty=1 for 10 cycles → fifo_read_en=0, m_valid=0, level=0 throughout.
- FIFO preloaded with 0x11,0x22,0x33,0x44, m_ready=1 → first m_valid 2 cycles after empty falls; words 0x11..0x44 on consecutive cycles; fifo_read_en never high while fifo_empty=1.
- Same preload, m_ready=0 → exactly 3 fifo_read_en pulses, level=3, m_data=0x11 held stable. Then raise m_ready → 0x11,0x22,0x33,0x44 delivered in order, with the 4th read issued one cycle after the first pop.
- Random m_ready (50%) over 1000 words with a FIFO refilled randomly:
  - output sequence equals input sequence;
  - count+inflight <= 3;
  - no overflow assertion fires.
- Assert rst while inflight=1 and level=2 → next cycle m_valid=0, level=0. Subsequent stream starts cleanly with the FIFO's post-reset first word.
- Pointer wrap: 7 words with alternating m_ready → 0..6 delivered in order across two wraps; level matches pushes minus pops every cycle.

Source files
------------

// File: rtl/iob_fifo_pkg.sv
// Shared constants and helpers for the FWFT read-side stage of the async FIFO.
// The output buffer is fixed at three entries, so pointers count modulo 3.
package iob_fifo_pkg;

   localparam int BUF_DEPTH = 3;
   localparam int LEVEL_W   = 2;
   localparam int PTR_W     = 2;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

endpackage

// File: rtl/iob_fifo_fwft_buf.sv
// Three-entry register buffer with push/pop, wrapping pointers and occupancy count.
// Push and pop in the same cycle leave the count unchanged and advance both pointers.
module iob_fifo_fwft_buf
   import iob_fifo_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic [LEVEL_W-1:0] count_o,
   output logic [DATA_W-1:0] head_o
);

   if (BUF_DEPTH != 3) begin : g_depth_check
      $error("iob_fifo_fwft_buf supports exactly three entries");
   end

   logic [DATA_W-1:0]  mem_q [BUF_DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LEVEL_W-1:0] count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_i) mem_q[wr_ptr_q] <= push_data_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   // The issue rule reserves a slot for every in-flight read, so this can only fire on a design bug.
   no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push_i && count_q == LEVEL_W'(BUF_DEPTH)))
      else $fatal(1, "push into full FWFT buffer");

endmodule

// File: rtl/iob_fifo_fwft_rd.sv
// Converts the FIFO's standard-mode read port (data one cycle after read_en) into a
// first-word-fall-through valid/ready stream at one word per cycle.
module iob_fifo_fwft_rd
   import iob_fifo_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              fifo_empty,
   output logic              fifo_read_en,
   input  logic [DATA_W-1:0] fifo_data_in,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [DATA_W-1:0] m_data,
   output logic [1:0]        level
);

   // Stream handshake: a word transfers on a cycle where m_valid and m_ready are both high;
   // while m_valid is high and m_ready low, m_valid and m_data hold unchanged.

   logic               inflight_q, inflight_d;
   logic [LEVEL_W-1:0] count;
   logic [LEVEL_W:0]   occupancy;
   logic               pop;

   // Issue depends only on registered state and fifo_empty, never on m_ready.
   always_comb begin
      occupancy    = {1'b0, count} + {{LEVEL_W{1'b0}}, inflight_q};
      fifo_read_en = ~fifo_empty & (occupancy < (LEVEL_W+1)'(BUF_DEPTH));
      inflight_d   = fifo_read_en;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) inflight_q <= 1'b0;
      else     inflight_q <= inflight_d;
   end

   assign pop     = m_valid & m_ready;
   assign m_valid = (count != '0);
   assign level   = count;

   iob_fifo_fwft_buf #(
      .DATA_W (DATA_W)
   ) u_buf (
      .clk         (clk),
      .rst         (rst),
      .push_i      (inflight_q),
      .push_data_i (fifo_data_in),
      .pop_i       (pop),
      .count_o     (count),
      .head_o      (m_data)
   );

endmodule

// File: tb/tb_iob_fifo_fwft_rd.sv
// Directed bench for iob_fifo_fwft_rd: cycle tables, pointer wrap, random backpressure
// with an ordering scoreboard, and reset while a read is in flight.
module tb_iob_fifo_fwft_rd;

   localparam int DATA_W = 8;
   localparam int N_RAND = 1000;

   logic              clk;
   logic              rst;
   logic              fifo_empty;
   logic              fifo_read_en;
   logic [DATA_W-1:0] fifo_data_in;
   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic [1:0]        level;

   int n_checks;
   int n_pass;

   logic [DATA_W-1:0] exp_q[$];

   iob_fifo_fwft_rd #(.DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .fifo_empty   (fifo_empty),
      .fifo_read_en (fifo_read_en),
      .fifo_data_in (fifo_data_in),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .m_data       (m_data),
      .level        (level)
   );

   // clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Standard-mode FIFO model: data_out registered one cycle after read_en; cleared by rst.
   logic [DATA_W-1:0] fifo_mem [0:4095];
   int wr_cnt;
   int rd_cnt;

   assign fifo_empty = (rd_cnt == wr_cnt);

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_cnt <= wr_cnt;
      end else if (fifo_read_en) begin
         fifo_data_in <= fifo_mem[rd_cnt];
         rd_cnt       <= rd_cnt + 1;
      end
   end

   // driver tasks
   task automatic fifo_load(input logic [DATA_W-1:0] w);
      fifo_mem[wr_cnt] = w;
      wr_cnt = wr_cnt + 1;
      exp_q.push_back(w);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
   endtask

   typedef struct {
      int         load_n;
      logic       m_ready;
      logic       exp_rd_en;
      logic       exp_valid;
      logic [1:0] exp_level;
      logic [7:0] exp_data;
   } vec_t;

   localparam int NV = 17;
   vec_t vec [NV];

   initial begin
      int word_id;
      int got;
      int exp_lvl;
      logic infl;
      logic popped;
      logic prev_valid, prev_ready;
      logic [DATA_W-1:0] prev_data;
      int nload;

      n_checks = 0;
      n_pass   = 0;
      wr_cnt   = 0;
      m_ready  = 1'b0;
      rst      = 1'b1;

      // Preload 11..44 with backpressure, then release; then 55..88 streamed at full rate.
      vec[0]  = '{4, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
      vec[1]  = '{0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00};
      vec[2]  = '{0, 1'b0, 1'b1, 1'b1, 2'd1, 8'h11};
      vec[3]  = '{0, 1'b0, 1'b0, 1'b1, 2'd2, 8'h11};
      vec[4]  = '{0, 1'b0, 1'b0, 1'b1, 2'd3, 8'h11};
      vec[5]  = '{0, 1'b1, 1'b0, 1'b1, 2'd3, 8'h11};
      vec[6]  = '{0, 1'b1, 1'b1, 1'b1, 2'd2, 8'h22};
      vec[7]  = '{0, 1'b1, 1'b0, 1'b1, 2'd1, 8'h33};
      vec[8]  = '{0, 1'b1, 1'b0, 1'b1, 2'd1, 8'h44};
      vec[9]  = '{0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};
      vec[10] = '{4, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
      vec[11] = '{0, 1'b1, 1'b1, 1'b0, 2'd0, 8'h00};
      vec[12] = '{0, 1'b1, 1'b1, 1'b1, 2'd1, 8'h55};
      vec[13] = '{0, 1'b1, 1'b1, 1'b1, 2'd1, 8'h66};
      vec[14] = '{0, 1'b1, 1'b0, 1'b1, 2'd1, 8'h77};
      vec[15] = '{0, 1'b1, 1'b0, 1'b1, 2'd1, 8'h88};
      vec[16] = '{0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00};

      #1;
      chk("reset m_valid", m_valid, 0);
      chk("reset m_data", m_data, 0);
      chk("reset level", level, 0);
      chk("reset fifo_read_en", fifo_read_en, 0);
      tick();
      tick();
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         tick();
         chk($sformatf("idle%0d rd_en", i), fifo_read_en, 0);
         chk($sformatf("idle%0d m_valid", i), m_valid, 0);
         chk($sformatf("idle%0d level", i), level, 0);
      end

      word_id = 0;
      for (int i = 0; i < NV; i++) begin
         for (int k = 0; k < vec[i].load_n; k++) begin
            word_id++;
            fifo_load(8'(8'h11 * word_id));
         end
         m_ready = vec[i].m_ready;
         #1;
         chk($sformatf("tbl%0d rd_en", i), fifo_read_en, vec[i].exp_rd_en);
         chk($sformatf("tbl%0d m_valid", i), m_valid, vec[i].exp_valid);
         chk($sformatf("tbl%0d level", i), level, vec[i].exp_level);
         if (vec[i].exp_valid) chk($sformatf("tbl%0d m_data", i), m_data, vec[i].exp_data);
         tick();
      end

      // Pointer wrap: 7 words, alternating m_ready, level tracked as pushes minus pops.
      exp_q.delete();
      for (int w = 0; w < 7; w++) fifo_load(8'(w));
      exp_lvl = 0;
      infl    = 1'b0;
      got     = 0;
      for (int cyc = 0; cyc < 80 && got < 7; cyc++) begin
         m_ready = (cyc % 2 == 1);
         #1;
         chk("wrap level", level, 32'(exp_lvl));
         popped = m_valid & m_ready;
         if (popped) begin
            if (exp_q.size() == 0) chk("wrap extra word", 1, 0);
            else chk($sformatf("wrap word%0d", got), m_data, exp_q.pop_front());
            got++;
         end
         exp_lvl = exp_lvl + (infl ? 1 : 0) - (popped ? 1 : 0);
         infl    = fifo_read_en;
         tick();
      end
      chk("wrap words delivered", got, 7);

      // Random backpressure and random refill with an ordering scoreboard.
      exp_q.delete();
      got        = 0;
      nload      = 0;
      infl       = 1'b0;
      prev_valid = 1'b0;
      prev_ready = 1'b0;
      prev_data  = '0;
      tick();
      tick();
      for (int cyc = 0; cyc < 8000 && got < N_RAND; cyc++) begin
         if (nload < N_RAND && $urandom_range(0, 1) == 1) begin
            fifo_load(8'($urandom_range(0, 255)));
            nload++;
         end
         m_ready = 1'($urandom_range(0, 1));
         #1;
         chk("rand rd_en while empty", fifo_read_en & fifo_empty, 0);
         chk("rand occupancy bound", 32'(level) + (infl ? 1 : 0) <= 3, 1);
         if (prev_valid && !prev_ready) begin
            chk("rand valid held", m_valid, 1);
            chk("rand data held", m_data, prev_data);
         end
         if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("rand extra word", 1, 0);
            else chk($sformatf("rand word%0d", got), m_data, exp_q.pop_front());
            got++;
         end
         prev_valid = m_valid;
         prev_ready = m_ready;
         prev_data  = m_data;
         infl       = fifo_read_en;
         tick();
      end
      chk("rand words delivered", got, N_RAND);

      // Reset while a read is in flight with two words buffered.
      m_ready = 1'b0;
      tick();
      tick();
      tick();
      for (int k = 0; k < 5; k++) fifo_load(8'(8'hC0 + k));
      #1;
      chk("rstmid issue", fifo_read_en, 1);
      tick();
      tick();
      tick();
      chk("rstmid pre level", level, 2);
      chk("rstmid pre rd_en", fifo_read_en, 0);
      rst = 1'b1;
      #1;
      chk("rstmid m_valid", m_valid, 0);
      chk("rstmid level", level, 0);
      chk("rstmid rd_en", fifo_read_en, 0);
      tick();
      rst = 1'b0;
      tick();
      chk("rstmid post m_valid", m_valid, 0);
      chk("rstmid post level", level, 0);
      exp_q.delete();
      fifo_load(8'hA5);
      m_ready = 1'b1;
      #1;
      chk("rstmid restart issue", fifo_read_en, 1);
      tick();
      chk("rstmid restart latency", m_valid, 0);
      tick();
      chk("rstmid restart valid", m_valid, 1);
      chk("rstmid restart data", m_data, 8'hA5);
      tick();
      chk("rstmid drained valid", m_valid, 0);
      chk("rstmid drained level", level, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
